// File: rtl/riscv_pkg.sv
// Shared types for the EX-stage divide sequencer: operation encoding, FSM states, iteration count.
package riscv_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam int DIV_ITER = 32;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor, keep if non-negative.
module div_restore_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // rem < divisor on entry, so the shifted value stays below 2*divisor and
  // the MSB of the 33-bit difference is a reliable sign.
  assign rem_sh = {rem_i, quo_i[XLEN-1]};
  assign diff   = rem_sh - {1'b0, divisor_i};

  always_comb begin
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer for EX; holds the result until acknowledged.
// Optional MD_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip straight from IDLE to DONE.
module ex_div_seq
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            start_ready,
  input  div_op_e         div_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            kill,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  input  logic            result_ack
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q;
  logic [4:0]      count_q;
  div_op_e         op_q;
  logic            sign_a_q, sign_b_q, special_q;
  logic [XLEN-1:0] rem_q, quo_q, divisor_q, spec_res_q, result_q;
  logic [XLEN-1:0] rem_d, quo_d;

  logic            is_signed_in, is_rem_in, a_neg, b_neg, div_zero, ovf, special_in;
  logic [XLEN-1:0] abs_a, abs_b, spec_val;
  logic            op_is_rem;
  logic [XLEN-1:0] q_fix, r_fix, fix_res;

  assign is_signed_in = (div_op == OP_DIV) || (div_op == OP_REM);
  assign is_rem_in    = (div_op == OP_REM) || (div_op == OP_REMU);
  assign a_neg        = is_signed_in && operand_a[XLEN-1];
  assign b_neg        = is_signed_in && operand_b[XLEN-1];
  assign abs_a        = a_neg ? -operand_a : operand_a;
  assign abs_b        = b_neg ? -operand_b : operand_b;

  // Special results are resolved at accept time so both builds return identical values.
  assign div_zero   = (operand_b == '0);
  assign ovf        = is_signed_in && (operand_a == INT_MIN) && (operand_b == '1);
  assign special_in = div_zero || ovf;
  assign spec_val   = div_zero ? (is_rem_in ? operand_a : '1)
                               : (is_rem_in ? '0 : INT_MIN);

  assign op_is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
  assign q_fix     = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
  assign r_fix     = sign_a_q ? -rem_q : rem_q;
  assign fix_res   = special_q ? spec_res_q : (op_is_rem ? r_fix : q_fix);

  div_restore_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      op_q       <= OP_DIV;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      special_q  <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      spec_res_q <= '0;
      result_q   <= '0;
    end else if (kill) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q       <= div_op;
            sign_a_q   <= a_neg;
            sign_b_q   <= b_neg;
            quo_q      <= abs_a;
            divisor_q  <= abs_b;
            rem_q      <= '0;
            count_q    <= 5'(DIV_ITER - 1);
            special_q  <= special_in;
            spec_res_q <= spec_val;
`ifdef MD_DIV_EARLY_OUT_EN
            if (special_in) begin
              state_q  <= ST_DONE;
              result_q <= spec_val;
            end else begin
              state_q  <= ST_CALC;
            end
`else
            state_q    <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (count_q == 5'd0) state_q <= ST_FIX;
          else                 count_q <= count_q - 5'd1;
        end
        ST_FIX: begin
          result_q <= fix_res;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          if (result_ack) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign result_valid = (state_q == ST_DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed self-checking bench for ex_div_seq: values, latency, kill, ack hold and reset.
module tb_ex_div_seq;
  import riscv_pkg::*;

`ifdef MD_DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif
  localparam int FULL_LAT = 34;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        start_ready;
  div_op_e     div_op = OP_DIV;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic        result_ack = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ex_div_seq #(.XLEN(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .start_ready  (start_ready),
    .div_op       (div_op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .kill         (kill),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .result_ack   (result_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op, measure latency to result_valid, optionally hold in DONE, then acknowledge.
  task automatic do_op(input string tag, input div_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input int hold);
    int lat;
    @(negedge clk);
    div_op = op; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!result_valid && lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_hold_valid"}, 32'(result_valid), 32'd1);
      chk({tag, "_hold_res"}, result, exp);
      chk({tag, "_hold_rdy"}, 32'(start_ready), 32'd0);
    end
    result_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ack = 1'b0;
    chk({tag, "_ack_rdy"}, 32'(start_ready), 32'd1);
    chk({tag, "_ack_valid"}, 32'(result_valid), 32'd0);
    $display("op %s a=%h b=%h res=%h lat=%0d", tag, a, b, result, lat);
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_rdy", 32'(start_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    do_op("div_100_7",  OP_DIV,  32'd100, 32'd7, 32'd14, FULL_LAT, 0);
    do_op("rem_m7_2",   OP_REM,  -32'sd7, 32'd2, 32'hFFFF_FFFF, FULL_LAT, 0);
    do_op("divu_max_2", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, FULL_LAT, 0);
    do_op("div_m100_7", OP_DIV,  -32'sd100, 32'd7, 32'hFFFF_FFF2, FULL_LAT, 0);
    do_op("rem_m100_7", OP_REM,  -32'sd100, 32'd7, 32'hFFFF_FFFE, FULL_LAT, 0);
    do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT, 0);
    do_op("divu_dz",    OP_DIVU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 0);
    do_op("rem_m5_dz",  OP_REM,  -32'sd5, 32'd0, 32'hFFFF_FFFB, SPEC_LAT, 0);
    do_op("div_5_dz",   OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 0);
    do_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, 0);
    do_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT, 0);

    // Kill during CALC cycle 10.
    @(negedge clk);
    div_op = OP_DIV; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy_after", 32'(busy), 32'd0);
    chk("kill_rdy_after", 32'(start_ready), 32'd1);
    chk("kill_valid_after", 32'(result_valid), 32'd0);
    $display("op kill_calc busy=%0d start_ready=%0d", busy, start_ready);
    do_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, FULL_LAT, 0);

    // Hold DONE for 5 cycles with a start issued during DONE.
    do_op("hold_div", OP_DIV, 32'd77, -32'sd7, 32'hFFFF_FFF5, FULL_LAT, 5);

    // kill and start in the same IDLE cycle: not accepted.
    @(negedge clk);
    div_op = OP_DIVU; operand_a = 32'd50; operand_b = 32'd5; start = 1'b1; kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("kill_start_rdy", 32'(start_ready), 32'd1);
    chk("kill_start_busy", 32'(busy), 32'd0);
    $display("op kill_start start_ready=%0d busy=%0d", start_ready, busy);

    // Reset in cycle 20 of an operation.
    @(negedge clk);
    div_op = OP_DIVU; operand_a = 32'd123; operand_b = 32'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(result_valid), 32'd0);
    chk("mid_rst_res", result, 32'd0);
    chk("mid_rst_rdy", 32'(start_ready), 32'd1);
    $display("op mid_reset busy=%0d result=%h", busy, result);
    @(negedge clk);
    reset_n = 1'b1;
    do_op("post_rst", OP_DIV, 32'd100, 32'd7, 32'd14, FULL_LAT, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
